// File: rtl/adder_tree_pipe.sv
// rtl/adder_tree_pipe.sv - pipelined signed adder tree with saturating frame accumulate
module adder_tree_pipe #(
   parameter int N_IN  = 8,
   parameter int IN_W  = 19,
   parameter int OUT_W = 23,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [N_IN*IN_W-1:0]     in_data,
   input  logic                     in_acc,
   input  logic                     in_last,
   output logic                     out_valid,
   output logic signed [OUT_W-1:0]  out_data,
   output logic                     out_sat,
   output logic [CNT_W-1:0]         out_beats
);

   localparam int L  = $clog2(N_IN);
   localparam int SW = IN_W + L;

   // Bad parameter sets are rejected at elaboration rather than silently wrapping.
   if (N_IN < 2 || (1 << L) != N_IN) begin : g_bad_n_in
      $error("adder_tree_pipe: N_IN must be a power of two >= 2");
   end
   if (OUT_W < SW) begin : g_bad_out_w
      $error("adder_tree_pipe: OUT_W must be >= IN_W + log2(N_IN)");
   end

   // Leaves are the sign-extended operands; node[1..N_IN-1] form a heap-ordered
   // tree where node i sums children 2i and 2i+1, so every level is one register.
   logic signed [SW-1:0] leaf [N_IN];
   logic signed [SW-1:0] node [1:N_IN-1];

   genvar k, i;
   for (k = 0; k < N_IN; k++) begin : g_leaf
      assign leaf[k] = SW'(signed'(in_data[k*IN_W +: IN_W]));
   end

   for (i = 1; i < N_IN; i++) begin : g_node
      if (2*i >= N_IN) begin : g_first
         // First tree level: add a pair of operands.
         always_ff @(posedge clk)
            node[i] <= leaf[2*i-N_IN] + leaf[2*i+1-N_IN];
      end else begin : g_inner
         // Inner tree level: add a pair of registered partial sums.
         always_ff @(posedge clk)
            node[i] <= node[2*i] + node[2*i+1];
      end
   end

   // Sideband shift registers, one bit per tree level, aligned with node[1].
   logic [L-1:0] v_sr, acc_sr, last_sr;

   // Move valid/mode/last alongside the data; reset drops in-flight beats.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_sr    <= '0;
         acc_sr  <= '0;
         last_sr <= '0;
      end else begin
         v_sr    <= L'({v_sr, in_valid});
         acc_sr  <= L'({acc_sr, in_acc});
         last_sr <= L'({last_sr, in_last});
      end
   end

   logic                    beat_v, beat_acc, beat_last;
   logic signed [OUT_W-1:0] sum;
   logic signed [OUT_W-1:0] acc_q, acc_nx;
   logic [CNT_W-1:0]        cnt_q, cnt_nx;
   logic                    sat_q, sat_nx, open_q;
   logic [OUT_W:0]          wide;

   assign beat_v    = v_sr[L-1];
   assign beat_acc  = acc_sr[L-1];
   assign beat_last = last_sr[L-1];
   assign sum       = OUT_W'(node[1]);

   // Next accumulator state: a closed frame restarts from the tree sum, an open
   // one adds with one guard bit and clips, so a clipped value is the new base.
   always_comb begin
      wide   = {acc_q[OUT_W-1], acc_q} + {sum[OUT_W-1], sum};
      acc_nx = sum;
      cnt_nx = CNT_W'(1);
      sat_nx = 1'b0;
      if (open_q) begin
         if (wide[OUT_W] != wide[OUT_W-1]) begin
            acc_nx = wide[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            sat_nx = 1'b1;
         end else begin
            acc_nx = wide[OUT_W-1:0];
            sat_nx = sat_q;
         end
         cnt_nx = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      end
   end

   // Output stage: pass-through beats emit directly and leave the frame alone;
   // accumulate beats update the frame and emit only when they close it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         out_beats <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         sat_q     <= 1'b0;
         open_q    <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (beat_v) begin
            if (!beat_acc) begin
               out_valid <= 1'b1;
               out_data  <= sum;
               out_sat   <= 1'b0;
               out_beats <= CNT_W'(1);
            end else begin
               acc_q  <= acc_nx;
               cnt_q  <= cnt_nx;
               sat_q  <= sat_nx;
               open_q <= !beat_last;
               if (beat_last) begin
                  out_valid <= 1'b1;
                  out_data  <= acc_nx;
                  out_sat   <= sat_nx;
                  out_beats <= cnt_nx;
               end
            end
         end
      end
   end

endmodule

// File: doc/adder_tree_pipe.md
Name: adder_tree_pipe

Overview:
- Parametrised, pipelined signed adder tree. Reduces N_IN signed IN_W-bit operands to one OUT_W-bit sum, with one register stage per tree level.
- Optional per-beat frame-accumulate mode: successive tree sums are added with saturation until a frame-end marker arrives.
- Sits between the MAC/product stages and the output formatter of the datapath. Streams one vector per cycle with a valid qualifier and no backpressure.

Parameters:
- N_IN, 8, number of operands; power of two, >=2; tree depth L = log2(N_IN).
- IN_W, 19, operand width, signed two's complement.
- OUT_W, 23, output/accumulator width; must be >= IN_W+L (elaboration error otherwise).
- CNT_W, 8, width of the frame beat counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous reset, active low.
- in_valid  in  1  input beat qualifier.
- in_data  in  N_IN*IN_W  packed operands; operand k = in_data[k*IN_W +: IN_W].
- in_acc  in  1  beat mode: 0 = pass-through sum, 1 = accumulate into open frame.
- in_last  in  1  closes the accumulate frame (ignored when in_acc=0).
- out_valid  out  1  one-cycle pulse, result valid.
- out_data  out  OUT_W  signed result.
- out_sat  out  1  result was clipped (frame-sticky); qualified by out_valid.
- out_beats  out  CNT_W  beats in the emitted frame (1 for pass-through).

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): every pipeline valid bit cleared; in-flight beats are discarded, not emitted. Accumulator = 0, frame-open = 0, beat counter = 0. Outputs: out_valid=0, out_data=0, out_sat=0, out_beats=0.
- Sign extension: operands are sign-extended to IN_W+L at stage 0.
- Tree: level j adds pairs from level j-1 and registers the result. Tree sums are exact; there is no overflow inside the tree.
- Sideband: in_valid, in_acc and in_last are pipelined alongside the data through all L levels.
- Output stage: one extra register. Total latency is L+1 cycles from the in_valid edge to the out_valid pulse; 4 cycles for the defaults.
- Throughput: one beat per cycle. Beat order is preserved. Bubbles (in_valid=0) propagate as bubbles.
- Pass-through beat (acc=0):
  - out_data = sign-extended tree sum, out_sat=0, out_beats=1.
  - Does not modify the accumulator, frame-open flag or counter. An open frame survives interleaved pass-through beats.
- Accumulate beat (acc=1):
  - If the frame is not open: acc = sum, cnt = 1, sat_flag = 0, frame-open = 1.
  - Otherwise: acc = sat(acc + sum), cnt = cnt+1 (saturates at 2^CNT_W-1).
  - sat() clips to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; any clip sets sat_flag.
  - Once saturated, further addition resumes from the clipped value (no wrap).
  - No output unless last=1.
- Accumulate beat with last=1:
  - Emit out_valid=1, out_data = updated acc, out_sat = sat_flag (including a clip on this beat), out_beats = updated cnt.
  - Then frame-open = 0. A single-beat frame (first beat with last=1) is legal.
- Hold behaviour: out_data, out_sat and out_beats hold their last emitted values while out_valid=0.
- in_last is ignored on pass-through beats; it neither closes nor opens a frame.
- in_data, in_acc and in_last are don't-care when in_valid=0.

Test Plan:
- Pass-through: N_IN=8, all operands = 1, acc=0 → exactly 4 cycles later out_valid=1, out_data=8, out_sat=0, out_beats=1.
- Negative extreme: all operands = -262144 → out_data = -2097152 (0x600000), out_sat=0. All operands = 262143 → 2097144.
- Streaming: 3 back-to-back beats with operand sets all-1, all-2, all--3 → out_valid on 3 consecutive cycles with 8, 16, -24. Then a 1-cycle bubble in → 1-cycle gap out.
- Accumulate: 4 beats of all-1000, acc=1, last on beat 4 → one out_valid only, 32000, out_beats=4, out_sat=0.
- Accumulate with an interleaved pass-through beat (all-1) between beats 2 and 3 → that beat emits 8, and the frame still totals 32000.
- Saturation: 3 beats of all-262143, acc=1, last on beat 3 → out_data = 4194303 (0x3FFFFF), out_sat=1, out_beats=3.
- Next frame: 1 beat of all-1 with last → 8, out_sat=0 (sticky flag cleared).
- Reset mid-frame: 2 accumulate beats of all-7, no last; rst_n=0 for 1 cycle while beats are in flight → no out_valid, outputs read 0. Then 1 beat all-5, acc=1, last=1 → out_data=40, out_beats=1.
